// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder controller: FSM encoding and slice width.
package serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result valid/ready channels between producer, controller and consumer.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_nibble_add_slice.sv
// Combinational 4-bit ripple-carry slice built from four full-adder cells.
module nibble_add_slice
  import serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle, LSB first, through a single 4-bit slice.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic              busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  nibble_add_slice u_slice (
    .a  (a_sh[SLICE_W-1:0]),
    .b  (b_sh[SLICE_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // The counter parks on the last slice index instead of wrapping; it is cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[SLICE_W*int'(cnt) +: SLICE_W] <= slice_s;
          carry <= slice_co;
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          if (cnt == LAST) begin
            cout_r <= slice_co;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed vector table, backpressure and reset sequences, then random traffic.
module tb_serial_add_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs [6];
  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_q[$];
  int          got = 0;
  bit          prod_stuck = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operand set, and returns just after the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    @(negedge clk);
    while (!bus.out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!bus.out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int e;
    bus.out_ready = 1'b1;
    applyStimulus(v.a, v.b, v.cin);
    waitResult(e);
    checkOutput({tag, "_latency"}, e, NSLICE);
    checkOutput({tag, "_sum"}, bus.sum, v.sum);
    checkOutput({tag, "_cout"}, bus.cout, v.cout);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
    checkOutput({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] held_sum;
    logic        held_cout;
    int          e;
    bit          seen_valid;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    checkOutput("reset_in_ready", bus.in_ready, 1'b1);
    checkOutput("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_sum", bus.sum, 16'h0000);
    checkOutput("reset_cout", bus.cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for six cycles while a stray operand pulse is offered.
    bus.out_ready = 1'b0;
    applyStimulus(16'h2468, 16'h1357, 1'b0);
    waitResult(e);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    checkOutput("bp_sum", held_sum, 16'h37BF);
    checkOutput("bp_cout", held_cout, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("bp_out_valid_c%0d", c), bus.out_valid, 1'b1);
      checkOutput($sformatf("bp_in_ready_c%0d", c), bus.in_ready, 1'b0);
      checkOutput($sformatf("bp_sum_stable_c%0d", c), bus.sum, 16'h37BF);
      checkOutput($sformatf("bp_cout_stable_c%0d", c), bus.cout, 1'b0);
      if (c == 1) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
      end
      if (c == 2) bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release_out_valid", bus.out_valid, 1'b0);
    checkOutput("bp_release_in_ready", bus.in_ready, 1'b1);
    checkOutput("bp_sum_kept", bus.sum, 16'h37BF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_stray_not_taken", busy, 1'b0);

    // Asynchronous reset in the third RUN cycle discards the partial result.
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready", bus.in_ready, 1'b1);
    checkOutput("arst_out_valid", bus.out_valid, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_sum", bus.sum, 16'h0000);
    checkOutput("arst_cout", bus.cout, 1'b0);
    #1 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    checkOutput("arst_no_stale_result", seen_valid, 1'b0);
    runVector(vecs[5], "after_reset");

    // Random traffic: producer stalls on in_valid, consumer toggles out_ready.
    fork
      begin : producer
        for (int i = 0; i < 1000 && !prod_stuck; i++) begin
          logic [15:0] ra, rb;
          logic        rc;
          bit          acc;
          int          n;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom_range(0, 1));
          bus.a        = ra;
          bus.b        = rb;
          bus.cin      = rc;
          bus.in_valid = 1'b1;
          acc = 1'b0;
          n   = 0;
          while (!acc && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
              acc = 1'b1;
              exp_q.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
            end
            @(posedge clk);
            #1;
            n++;
          end
          bus.in_valid = 1'b0;
          if (!acc) begin
            checkOutput("rand_accept_timeout", 32'd0, 32'd1);
            prod_stuck = 1'b1;
          end
        end
      end
      begin : consumer
        int cyc = 0;
        logic [16:0] ev;
        while (got < 1000 && cyc < 40000 && !prod_stuck) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              checkOutput("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
              ev = exp_q.pop_front();
              checkOutput($sformatf("rand_result%0d", got), {15'd0, bus.cout, bus.sum}, {15'd0, ev});
            end
            got++;
          end
          cyc++;
        end
      end
    join
    checkOutput("rand_result_count", got, 32'd1000);
    checkOutput("rand_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Multi-cycle controller that adds two WIDTH-bit operands by sequencing one 4-bit ripple-carry slice over WIDTH/4 clock cycles, LSB nibble first. A registered carry links consecutive slices. Sits between an upstream operand producer and a downstream result consumer. Both sides use valid/ready handshakes. Trades latency for one small adder, with no wide combinational carry chain.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NSLICE, WIDTH/4, derived local constant: number of slice cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b/cin valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result bits
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice counter=0, carry reg=0, operand shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch a, b into shift regs, carry reg<=cin, counter<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: in_ready=0, busy=1. Each cycle:
  - Slice adds a_sh[3:0] + b_sh[3:0] + carry reg.
  - The 4-bit slice result is written to sum bits [4k+3:4k], where k=counter.
  - Carry reg <= slice carry; a_sh and b_sh shift right by 4.
  - counter++ each cycle.
  - When counter==NSLICE-1: go to DONE and cout<=slice carry.
- DONE: out_valid=1, busy=1, in_ready=0.
  - sum and cout are held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE; in_ready is 1 the next cycle.
- Latency: accept edge at cycle 0; out_valid high from cycle NSLICE+1 (cycle 5 for WIDTH=16). Minimum initiation interval is NSLICE+2 cycles.
- Width rules:
  - Arithmetic is modulo 2^WIDTH; cout is the true carry.
  - sum/cout keep their last value after handshake until overwritten by the next operation.
- Boundary conditions:
  - in_valid while busy: ignored, because in_ready=0. The upstream must hold its operands.
  - out_ready high before out_valid: no effect.
  - out_ready high on the first DONE cycle: 1-cycle DONE.
  - WIDTH=4: RUN lasts exactly one cycle.
  - Counter width is clog2(NSLICE), minimum 1 bit. It never wraps past NSLICE-1.
  - rst_n asserted in any state: immediate return to the reset values above. A partial result is discarded and never presented.
- No combinational path from in_valid to out_valid. in_ready and out_valid are decoded from the state register only.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Slice width constant SLICE_W=4.
- Sub-module nibble_add_slice: purely combinational 4-bit ripple-carry slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co.
  - Built from four full-adder cells; instantiated once.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0; out_ready held 1 -> out_valid at cycle 5, sum=0x5555, cout=0; in_ready high again at cycle 6.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 slice cycles). Repeat with a=0xFFFF, b=0x0000, cin=1 -> same result.
- a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1; then a=0x00FF, b=0x0F01, cin=0 -> sum=0x1000, cout=0, with no carry leaking from the previous operation.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0 throughout. A new in_valid pulse with a=0x1111 during this window is not accepted. Raising out_ready -> handshake, IDLE next cycle.
- Async reset: pulse rst_n low in the third RUN cycle of 0xABCD+0x1111, between clock edges -> outputs reset immediately, out_valid never rises. The next operation 0x0001+0x0002 -> sum=0x0003, cout=0.
- Random: 1000 operand pairs with random in_valid/out_ready stalls -> sum/cout match (a+b+cin) mod 2^16 and bit 16. Exactly one result per accepted input, in order.
